// File: rtl/axi4l_pkg.sv
// Shared types and default widths for the AXI4-Lite master bridge.
package axi4l_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDRESS_WIDTH = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RSP
  } state_e;

endpackage

// File: rtl/axi4l_vld_hold.sv
// Per-channel valid/payload holder: load sets valid and captures payload,
// the valid clears on the handshake while the payload stays put.
module axi4l_vld_hold #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/axi4l_master_bridge.sv
// Single-beat command/response to AXI4-Lite master bridge, one transaction in flight.
// Define AXI4L_MASTER_ERR_CNT_EN to add the err_count / err_last_addr outputs.
module axi4l_master_bridge
  import axi4l_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [ADDRESS_WIDTH-1:0]  awaddr,
  output logic                      wvalid,
  input  logic                      wready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      bvalid,
  output logic                      bready,
  input  logic [1:0]                bresp,
  output logic                      arvalid,
  input  logic                      arready,
  output logic [ADDRESS_WIDTH-1:0]  araddr,
  input  logic                      rvalid,
  output logic                      rready,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp
`ifdef AXI4L_MASTER_ERR_CNT_EN
  ,
  output logic [15:0]               err_count,
  output logic [ADDRESS_WIDTH-1:0]  err_last_addr
`endif
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_e                  state_q;
  logic                    cmd_ready_q, bready_q, rready_q;
  logic                    rsp_valid_q, rsp_write_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]              rsp_resp_q;

  logic accept, wr_load, rd_load, aw_done, w_done;
  logic [DATA_WIDTH+STRB_WIDTH-1:0] w_payload;

  assign accept  = cmd_valid && cmd_ready_q;
  assign wr_load = accept && cmd_write;
  assign rd_load = accept && !cmd_write;
  // A channel counts as done once its valid has dropped or is handshaking now.
  assign aw_done = !awvalid || awready;
  assign w_done  = !wvalid || wready;

  axi4l_vld_hold #(.W(ADDRESS_WIDTH)) u_aw_hold (
    .clk(clk), .rst_n(rst_n), .load_i(wr_load), .data_i(cmd_addr),
    .ready_i(awready), .valid_o(awvalid), .data_o(awaddr)
  );

  axi4l_vld_hold #(.W(DATA_WIDTH + STRB_WIDTH)) u_w_hold (
    .clk(clk), .rst_n(rst_n), .load_i(wr_load), .data_i({cmd_wstrb, cmd_wdata}),
    .ready_i(wready), .valid_o(wvalid), .data_o(w_payload)
  );

  assign wstrb = w_payload[DATA_WIDTH +: STRB_WIDTH];
  assign wdata = w_payload[DATA_WIDTH-1:0];

  axi4l_vld_hold #(.W(ADDRESS_WIDTH)) u_ar_hold (
    .clk(clk), .rst_n(rst_n), .load_i(rd_load), .data_i(cmd_addr),
    .ready_i(arready), .valid_o(arvalid), .data_o(araddr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cmd_ready_q <= 1'b0;
            state_q     <= cmd_write ? WR_REQ : RD_REQ;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        WR_REQ: begin
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= bresp;
            state_q     <= RSP;
          end
        end
        RD_REQ: begin
          if (arvalid && arready) begin
            rready_q <= 1'b1;
            state_q  <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (rvalid) begin
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= rdata;
            rsp_resp_q  <= rresp;
            state_q     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign bready    = bready_q;
  assign rready    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

`ifdef AXI4L_MASTER_ERR_CNT_EN
  logic                     capture;
  logic [1:0]               cap_resp;
  logic [15:0]              err_count_q;
  logic [ADDRESS_WIDTH-1:0] err_last_addr_q;

  assign capture  = (state_q == WR_RESP && bvalid) || (state_q == RD_RESP && rvalid);
  assign cap_resp = (state_q == WR_RESP) ? bresp : rresp;

  // The address holders keep their payload after the handshake, so they
  // still carry the faulting transaction's address at capture time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q     <= '0;
      err_last_addr_q <= '0;
    end else if (capture && resp_e'(cap_resp) != OKAY) begin
      if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
      err_last_addr_q <= (state_q == WR_RESP) ? awaddr : araddr;
    end
  end

  assign err_count     = err_count_q;
  assign err_last_addr = err_last_addr_q;
`endif

endmodule

// File: tb/tb_axi4l_master_bridge.sv
// Self-checking bench: table vectors, randomized traffic against a memory
// reference model, long response back-pressure and mid-transaction reset.
module tb_axi4l_master_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_ready, rsp_valid, rsp_write;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic        bvalid = 1'b0, rvalid = 1'b0;
  logic [31:0] awaddr, araddr, wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;
`ifdef AXI4L_MASTER_ERR_CNT_EN
  logic [15:0] err_count;
  logic [31:0] err_last_addr;
`endif

  always #5 clk = ~clk;

  axi4l_master_bridge #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
`ifdef AXI4L_MASTER_ERR_CNT_EN
    , .err_count(err_count), .err_last_addr(err_last_addr)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave-side memory (filled from what appears on the bus) and the
  // reference memory (filled from the commands the bench issued).
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  int          model_errs = 0;
  logic [31:0] model_last = '0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 32'h0;
  endfunction

  // One complete command: issue, act as slave with the given ready/response
  // delays, check the response, hold it for 'hold' cycles, then release.
  task automatic run_txn(input string tag, input bit wr, input logic [31:0] addr,
                         input logic [31:0] c_wdata, input logic [3:0] c_wstrb,
                         input int aw_dly, input int w_dly, input int ar_dly, input int rsp_dly,
                         input bit use_mem, input logic [31:0] s_rdata, input logic [1:0] s_resp,
                         input int hold, input logic [31:0] exp_rdata);
    int cyc;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, x_cnt = 0, b_acc = 0;
    bit aw_done = 0, w_done = 0, ar_done = 0, b_done = 0, r_done = 0;
    bit aw_pend = 0, w_pend = 0, ar_pend = 0, b_pend = 0, r_pend = 0;
    bit first = 1, seen_rsp = 0, bad_pay = 0, bad_win = 0, bad_hold = 0, mem_done = 0;
    logic [31:0] bus_awaddr = '0, bus_wdata = '0, bus_araddr = '0;
    logic [3:0]  bus_wstrb = '0;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = c_wdata; cmd_wstrb = c_wstrb;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin @(negedge clk); cyc++; end
    check({tag, ".accept"}, 64'(cmd_ready), 64'(1));

    cyc = 0;
    while (!seen_rsp && cyc < 200) begin
      @(negedge clk);
      cyc++;
      cmd_valid = 1'b0;
      if (aw_pend) aw_done = 1;
      if (w_pend)  w_done  = 1;
      if (ar_pend) ar_done = 1;
      if (b_pend)  b_done  = 1;
      if (r_pend)  r_done  = 1;
      if (first) begin
        check({tag, ".valid_1cyc"}, 64'({awvalid, wvalid, arvalid}),
              wr ? 64'(3'b110) : 64'(3'b001));
        first = 0;
      end
      if (rsp_valid) seen_rsp = 1;
      if (awvalid && (aw_done || awaddr !== addr)) bad_pay = 1;
      if (wvalid && (w_done || wdata !== c_wdata || wstrb !== c_wstrb)) bad_pay = 1;
      if (arvalid && (ar_done || araddr !== addr)) bad_pay = 1;
      if (bready && !(wr && aw_done && w_done && !b_done)) bad_win = 1;
      if (rready && !(!wr && ar_done && !r_done)) bad_win = 1;
      if (wr && aw_done && w_done && !mem_done) begin
        slave_mem[bus_awaddr] = merge(slave_rd(bus_awaddr), bus_wdata, bus_wstrb);
        mem_done = 1;
      end

      awready = awvalid && !aw_done && (aw_cnt >= aw_dly);
      if (awvalid && !aw_done) aw_cnt++;
      aw_pend = awvalid && awready;
      if (aw_pend) bus_awaddr = awaddr;
      wready = wvalid && !w_done && (w_cnt >= w_dly);
      if (wvalid && !w_done) w_cnt++;
      w_pend = wvalid && wready;
      if (w_pend) begin bus_wdata = wdata; bus_wstrb = wstrb; end
      arready = arvalid && !ar_done && (ar_cnt >= ar_dly);
      if (arvalid && !ar_done) ar_cnt++;
      ar_pend = arvalid && arready;
      if (ar_pend) bus_araddr = araddr;

      if (wr && aw_done && w_done && !b_done) begin
        bvalid = (x_cnt >= rsp_dly); bresp = s_resp; x_cnt++;
      end else bvalid = 1'b0;
      b_pend = bvalid && bready;
      if (b_pend) b_acc++;
      if (!wr && ar_done && !r_done) begin
        rvalid = (x_cnt >= rsp_dly); rresp = s_resp;
        rdata = use_mem ? slave_rd(bus_araddr) : s_rdata; x_cnt++;
      end else rvalid = 1'b0;
      r_pend = rvalid && rready;
    end
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;

    check({tag, ".rsp_valid"}, 64'(seen_rsp), 64'(1));
    check({tag, ".payload_stable"}, 64'(bad_pay), 64'(0));
    check({tag, ".ready_window"}, 64'(bad_win), 64'(0));
    check({tag, ".b_accepts"}, 64'(b_acc), wr ? 64'(1) : 64'(0));
    check({tag, ".rsp_write"}, 64'(rsp_write), 64'(wr));
    check({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
    check({tag, ".rsp_resp"}, 64'(rsp_resp), 64'(s_resp));
    if (s_resp != 2'b00) begin
      if (model_errs < 65535) model_errs++;
      model_last = addr;
    end
`ifdef AXI4L_MASTER_ERR_CNT_EN
    check({tag, ".err_count"}, 64'(err_count), 64'(model_errs));
    check({tag, ".err_last_addr"}, 64'(err_last_addr), 64'(model_last));
`endif
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid || cmd_ready || rsp_write !== wr || rsp_rdata !== exp_rdata ||
          rsp_resp !== s_resp) bad_hold = 1;
    end
    check({tag, ".hold_stable"}, 64'(bad_hold), 64'(0));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ".release"}, 64'({rsp_valid, cmd_ready}), 64'(2'b01));
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly, w_dly, ar_dly, rsp_dly;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          hold;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    bit          wr;
    logic [31:0] a, d, er;
    logic [3:0]  s;
    int          cyc;

    vecs[0] = '{1, 32'h0ABC_0040, 32'hDEAD_BEEF, 4'hF, 2, 3, 0, 0, 32'h0, 2'b00, 0, 32'h0};
    vecs[1] = '{1, 32'h0000_0010, 32'h1234_5678, 4'h3, 0, 0, 0, 1, 32'h0, 2'b10, 1, 32'h0};
    vecs[2] = '{0, 32'h0600_0000, 32'h0, 4'h0, 0, 0, 1, 0, 32'h00CD_AABB, 2'b00, 0, 32'h00CD_AABB};
    vecs[3] = '{1, 32'h0000_0080, 32'hA5A5_5A5A, 4'hC, 0, 0, 0, 0, 32'h0, 2'b00, 0, 32'h0};
    vecs[4] = '{0, 32'h0000_0200, 32'h0, 4'h0, 0, 0, 3, 2, 32'hCAFE_F00D, 2'b11, 10, 32'hCAFE_F00D};
    vecs[5] = '{1, 32'h0000_0300, 32'h0BAD_F00D, 4'h1, 3, 0, 0, 2, 32'h0, 2'b11, 2, 32'h0};
    vecs[6] = '{0, 32'h0000_0400, 32'h0, 4'h0, 0, 0, 0, 0, 32'h8000_0001, 2'b01, 0, 32'h8000_0001};

    // Reset state, sampled while reset is still asserted.
    #12;
    check("reset.valids_readies", 64'({awvalid, wvalid, arvalid, bready, rready, cmd_ready, rsp_valid}), 64'(0));
    check("reset.payloads", {awaddr, araddr} | 64'({wdata, wstrb}), 64'(0));
    check("reset.rsp", 64'({rsp_write, rsp_rdata, rsp_resp}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset.cmd_ready_after", 64'(cmd_ready), 64'(1));

    foreach (vecs[i])
      run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
              vecs[i].aw_dly, vecs[i].w_dly, vecs[i].ar_dly, vecs[i].rsp_dly, 1'b0,
              vecs[i].rdata, vecs[i].resp, vecs[i].hold, vecs[i].exp_rdata);

    // Random traffic over a small address window so reads hit earlier writes.
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 32'h100 + 32'(4 * $urandom_range(0, 7));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      if (wr) begin
        model_mem[a] = merge(model_rd(a), d, s);
        er = 32'h0;
      end else er = model_rd(a);
      run_txn($sformatf("rnd%0d", n), wr, a, d, s,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'b1, 32'h0, 2'($urandom_range(0, 3)),
              $urandom_range(0, 3), er);
    end

    // Reset asserted while waiting for B: everything drops without a clock edge.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin @(negedge clk); cyc++; end
    cyc = 0;
    do begin
      @(negedge clk);
      cmd_valid = 1'b0;
      awready = awvalid; wready = wvalid;
      cyc++;
    end while (!bready && cyc < 50);
    check("abort.reached_wr_resp", 64'(bready), 64'(1));
    awready = 0; wready = 0;
    #2 rst_n = 1'b0;
    #1;
    check("abort.async_clear", 64'({awvalid, wvalid, arvalid, bready, rready, cmd_ready, rsp_valid}), 64'(0));
    model_errs = 0;
    model_last = '0;
`ifdef AXI4L_MASTER_ERR_CNT_EN
    check("abort.err_regs", 64'({err_count, err_last_addr}), 64'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) cyc++;
    end
    check("abort.no_spurious_rsp", 64'(cyc), 64'(0));
    check("abort.idle_ready", 64'(cmd_ready), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
